// File: rtl/mem_access_ctrl_if.sv
// Request/grant handshake and datapath strobes between the control unit, the
// memory access controller and the MAR/MDR/memory datapath.
interface mem_access_ctrl_if;
  logic f_req;
  logic d_req;
  logic d_we;
  logic f_grant;
  logic d_grant;
  logic f_done;
  logic d_done;
  logic MARin;
  logic MDRin;
  logic read;
  logic mem_read;
  logic mem_write;
  logic busy;

  // Controller side.
  modport slave (
    input  f_req, d_req, d_we,
    output f_grant, d_grant, f_done, d_done,
    output MARin, MDRin, read, mem_read, mem_write, busy
  );

  // Requester / datapath side.
  modport master (
    output f_req, d_req, d_we,
    input  f_grant, d_grant, f_done, d_done,
    input  MARin, MDRin, read, mem_read, mem_write, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch (F) and data (D) requests, with D taking priority, and sequences
// MAR/MDR loads plus memory strobes for one transaction at a time.
module mem_access_ctrl #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned CNT_W       = 4
) (
  input logic              clock,
  input logic              clear,
  mem_access_ctrl_if.slave bus
);

  // A latency of 0 behaves exactly like a latency of 1.
  localparam int unsigned EffLat = (MEM_LATENCY == 0) ? 1 : MEM_LATENCY;
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(EffLat - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StAddr  = 3'd1;
  localparam logic [2:0] StWdata = 3'd2;
  localparam logic [2:0] StMem   = 3'd3;
  localparam logic [2:0] StLatch = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             own_f_q, own_f_d;
  logic             own_d_q, own_d_d;
  logic             we_q, we_d;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      own_f_q <= 1'b0;
      own_d_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_f_q <= own_f_d;
      own_d_q <= own_d_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_f_d = own_f_q;
    own_d_d = own_d_q;
    we_d    = we_q;
    case (state_q)
      StIdle: begin
        if (bus.d_req) begin
          own_d_d = 1'b1;
          we_d    = bus.d_we;
          state_d = StAddr;
        end else if (bus.f_req) begin
          own_f_d = 1'b1;
          we_d    = 1'b0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        cnt_d   = CntLoad;
        state_d = we_q ? StWdata : StMem;
      end
      StWdata: state_d = StMem;
      StMem: begin
        if (cnt_q == '0) begin
          state_d = we_q ? StDone : StLatch;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StLatch: state_d = StDone;
      StDone: begin
        state_d = StIdle;
        own_f_d = 1'b0;
        own_d_d = 1'b0;
        we_d    = 1'b0;
      end
      default: begin
        state_d = StIdle;
        own_f_d = 1'b0;
        own_d_d = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // Owner flags are only set from ADDR through DONE, so they double as the grants.
  always_comb begin
    bus.f_grant   = own_f_q;
    bus.d_grant   = own_d_q;
    bus.f_done    = own_f_q && (state_q == StDone);
    bus.d_done    = own_d_q && (state_q == StDone);
    bus.MARin     = (state_q == StAddr);
    bus.MDRin     = (state_q == StWdata) || (state_q == StLatch);
    bus.read      = (state_q == StLatch);
    bus.mem_read  = ((state_q == StMem) && !we_q) || (state_q == StLatch);
    bus.mem_write = (state_q == StMem) && we_q;
    bus.busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table-driven transactions plus hand-written corner cases,
// with per-cycle expected output vectors held in a scoreboard queue.
module tb_mem_access_ctrl;

  logic clock;
  logic clear;

  mem_access_ctrl_if bi2 ();
  mem_access_ctrl_if bi1 ();
  mem_access_ctrl_if bi15 ();

  mem_access_ctrl #(.MEM_LATENCY(2), .CNT_W(4)) dut2 (.clock(clock), .clear(clear), .bus(bi2));
  mem_access_ctrl #(.MEM_LATENCY(1), .CNT_W(4)) dut1 (.clock(clock), .clear(clear), .bus(bi1));
  mem_access_ctrl #(.MEM_LATENCY(15), .CNT_W(4)) dut15 (.clock(clock), .clear(clear), .bus(bi15));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Vector bits: {f_grant, d_grant, f_done, d_done, MARin, MDRin, read, mem_read, mem_write, busy}
  typedef struct {
    int         dut;
    logic [9:0] exp;
  } sb_t;

  typedef struct {
    bit f_req;
    bit d_req;
    bit d_we;
    bit exp_d;
    bit exp_we;
  } vec_t;

  sb_t   sb[$];
  vec_t  tbl[4];
  int    n_pass;
  int    n_total;
  string test_name;

  function automatic logic [9:0] outv(input int d);
    case (d)
      1:  outv = {bi1.f_grant, bi1.d_grant, bi1.f_done, bi1.d_done, bi1.MARin, bi1.MDRin,
                  bi1.read, bi1.mem_read, bi1.mem_write, bi1.busy};
      15: outv = {bi15.f_grant, bi15.d_grant, bi15.f_done, bi15.d_done, bi15.MARin, bi15.MDRin,
                  bi15.read, bi15.mem_read, bi15.mem_write, bi15.busy};
      default: outv = {bi2.f_grant, bi2.d_grant, bi2.f_done, bi2.d_done, bi2.MARin, bi2.MDRin,
                       bi2.read, bi2.mem_read, bi2.mem_write, bi2.busy};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic push(input int d, input logic [9:0] v);
    sb_t e;
    e.dut = d;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Expected cycle-by-cycle outputs of one transaction, ADDR through DONE.
  task automatic push_txn(input int d, input bit is_d, input bit we, input int lat);
    bit gf;
    bit gd;
    gf = !is_d;
    gd = is_d;
    push(d, {gf, gd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    if (we) push(d, {gf, gd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < lat; i++)
      push(d, {gf, gd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !we, we, 1'b1});
    if (!we) push(d, {gf, gd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    push(d, {gf, gd, gf, gd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic step();
    sb_t        e;
    logic [9:0] o;
    @(negedge clock);
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", test_name);
    end else begin
      e = sb.pop_front();
      o = outv(e.dut);
      chk(test_name, o, e.exp);
      chk({test_name, "_inv"}, {7'b0, o[2] & o[1], o[9] & o[8], o[3] & ~o[4]}, 10'b0);
    end
  endtask

  task automatic drop_reqs();
    bi2.f_req = 1'b0;  bi2.d_req = 1'b0;  bi2.d_we = 1'b0;
    bi1.f_req = 1'b0;  bi1.d_req = 1'b0;  bi1.d_we = 1'b0;
    bi15.f_req = 1'b0; bi15.d_req = 1'b0; bi15.d_we = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    tbl[0] = '{f_req: 1'b1, d_req: 1'b0, d_we: 1'b0, exp_d: 1'b0, exp_we: 1'b0};
    tbl[1] = '{f_req: 1'b0, d_req: 1'b1, d_we: 1'b1, exp_d: 1'b1, exp_we: 1'b1};
    tbl[2] = '{f_req: 1'b0, d_req: 1'b1, d_we: 1'b0, exp_d: 1'b1, exp_we: 1'b0};
    tbl[3] = '{f_req: 1'b1, d_req: 1'b0, d_we: 1'b1, exp_d: 1'b0, exp_we: 1'b0};

    drop_reqs();
    clear = 1'b0;
    #12;
    test_name = "reset";
    chk("reset_dut2", outv(2), 10'b0);
    chk("reset_dut1", outv(1), 10'b0);
    chk("reset_dut15", outv(15), 10'b0);
    @(negedge clock);
    clear = 1'b1;
    push(2, 10'b0);
    test_name = "idle_after_reset";
    step();

    // Table: one transaction per row on the MEM_LATENCY=2 instance.
    for (int i = 0; i < 4; i++) begin
      $sformat(test_name, "tbl%0d", i);
      bi2.f_req = tbl[i].f_req;
      bi2.d_req = tbl[i].d_req;
      bi2.d_we  = tbl[i].d_we;
      push_txn(2, tbl[i].exp_d, tbl[i].exp_we, 2);
      repeat (5) step();
      drop_reqs();
      push(2, 10'b0);
      step();
    end

    // Both requesters at once: D first, one IDLE cycle, then F.
    test_name = "both";
    bi2.f_req = 1'b1;
    bi2.d_req = 1'b1;
    push_txn(2, 1'b1, 1'b0, 2);
    repeat (5) step();
    bi2.d_req = 1'b0;
    push(2, 10'b0);
    step();
    push_txn(2, 1'b0, 1'b0, 2);
    repeat (5) step();
    drop_reqs();
    push(2, 10'b0);
    step();

    // d_we falls after grant: still a store.
    test_name = "we_toggle";
    bi2.d_req = 1'b1;
    bi2.d_we  = 1'b1;
    push_txn(2, 1'b1, 1'b1, 2);
    step();
    bi2.d_we = 1'b0;
    repeat (4) step();
    drop_reqs();
    push(2, 10'b0);
    step();

    // Reset during the second mem_read cycle, then a fresh fetch.
    test_name = "rst_mid";
    bi2.f_req = 1'b1;
    push_txn(2, 1'b0, 1'b0, 2);
    repeat (2) step();
    @(posedge clock);
    #2;
    chk("rst_mid_mem2", outv(2), 10'b1000000101);
    clear = 1'b0;
    #1;
    chk("rst_mid_async", outv(2), 10'b0);
    sb.delete();
    @(negedge clock);
    chk("rst_mid_held", outv(2), 10'b0);
    clear = 1'b1;
    test_name = "rst_restart";
    push_txn(2, 1'b0, 1'b0, 2);
    repeat (5) step();
    drop_reqs();
    push(2, 10'b0);
    step();

    // MEM_LATENCY=1 fetch load: done in cycle 4.
    test_name = "lat1";
    bi1.f_req = 1'b1;
    push_txn(1, 1'b0, 1'b0, 1);
    repeat (4) step();
    drop_reqs();
    push(1, 10'b0);
    step();

    // MEM_LATENCY=15 data load: done in cycle 18.
    test_name = "lat15";
    bi15.d_req = 1'b1;
    push_txn(15, 1'b1, 1'b0, 15);
    repeat (18) step();
    drop_reqs();
    push(15, 10'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
